// File: rtl/bingo_pkg.sv
// Shared types for the Bingo turn controller: FSM states, reject codes,
// and the default board size.
package bingo_pkg;

    typedef enum logic [1:0] {
        WAIT_KEY = 2'd0,
        CHECK    = 2'd1,
        ISSUE    = 2'd2,
        DONE     = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_RANGE = 2'b01;
    localparam logic [1:0] ERR_USED  = 2'b10;
    localparam logic [1:0] ERR_BCD   = 2'b11;

    localparam int MAX_NUM_DEF = 25;

endpackage

// File: rtl/bcd2_to_bin.sv
// Two-digit BCD to 7-bit binary; bcd_ok_o flags digits above 9.
// The binary result is meaningless when bcd_ok_o is low.
module bcd2_to_bin (
    input  logic [7:0] bcd_i,
    output logic [6:0] bin_o,
    output logic       bcd_ok_o
);

    assign bcd_ok_o = (bcd_i[7:4] <= 4'd9) && (bcd_i[3:0] <= 4'd9);
    assign bin_o    = {3'b000, bcd_i[7:4]} * 7'd10 + {3'b000, bcd_i[3:0]};

endmodule

// File: rtl/bingo_turn_ctrl.sv
// Turn scheduler for the shared Bingo keypad: validates picks, issues them
// to the board over valid/ready, alternates players. Optional: TURN_TIMEOUT_EN.
module bingo_turn_ctrl
    import bingo_pkg::*;
#(
    parameter int MAX_NUM = MAX_NUM_DEF
`ifdef TURN_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 500_000_000
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_game,
    input  logic [7:0]         display_num,
    input  logic               enter_pulse,
    input  logic               pick_ready,
    output logic               pick_valid,
    output logic [6:0]         pick_num,
    output logic               pick_player,
    output logic               cur_player,
    output logic               err_pulse,
    output logic [1:0]         err_code,
    output logic [MAX_NUM-1:0] used_mask,
    output logic               game_over,
    output logic               timeout_pulse
);

    state_e             state_q, state_d;
    logic [7:0]         entry_q, entry_d;
    logic               pick_valid_q, pick_valid_d;
    logic [6:0]         pick_num_q, pick_num_d;
    logic               pick_player_q, pick_player_d;
    logic               cur_player_q, cur_player_d;
    logic               err_pulse_q, err_pulse_d;
    logic [1:0]         err_code_q, err_code_d;
    logic [MAX_NUM-1:0] used_mask_q, used_mask_d;
    logic               tmo_pulse_q, tmo_pulse_d;

    logic [6:0]         val;
    logic               bcd_ok;
    logic               used_hit;
    logic [1:0]         chk_code;
    logic [MAX_NUM-1:0] pick_bit;
    logic               mask_full;

    bcd2_to_bin u_bcd (
        .bcd_i    (entry_q),
        .bin_o    (val),
        .bcd_ok_o (bcd_ok)
    );

    // Classify the captured entry; bad BCD outranks range, range outranks reuse
    always_comb begin
        used_hit = 1'b0;
        pick_bit = '0;
        for (int i = 0; i < MAX_NUM; i++) begin
            if (int'(val) == i + 1) used_hit = used_hit | used_mask_q[i];
            if (int'(pick_num_q) == i + 1) pick_bit[i] = 1'b1;
        end
        chk_code = ERR_NONE;
        if (!bcd_ok)
            chk_code = ERR_BCD;
        else if (val == 7'd0 || int'(val) > MAX_NUM)
            chk_code = ERR_RANGE;
        else if (used_hit)
            chk_code = ERR_USED;
        mask_full = &(used_mask_q | pick_bit);
    end

`ifdef TURN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    assign tmo_hit = (state_q == WAIT_KEY) && !enter_pulse &&
                     (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_d = '0;
        if (!new_game && state_q == WAIT_KEY && !enter_pulse && !tmo_hit)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    logic tmo_hit;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= WAIT_KEY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_KEY: if (enter_pulse) state_d = CHECK;
            CHECK:    state_d = (chk_code == ERR_NONE) ? ISSUE : WAIT_KEY;
            ISSUE:    if (pick_ready) state_d = mask_full ? DONE : WAIT_KEY;
            DONE:     state_d = DONE;
            default:  state_d = WAIT_KEY;
        endcase
        if (new_game) state_d = WAIT_KEY;
    end

    always_comb begin
        entry_d       = entry_q;
        pick_valid_d  = pick_valid_q;
        pick_num_d    = pick_num_q;
        pick_player_d = pick_player_q;
        cur_player_d  = cur_player_q;
        err_pulse_d   = 1'b0;
        err_code_d    = err_code_q;
        used_mask_d   = used_mask_q;
        tmo_pulse_d   = 1'b0;
        unique case (state_q)
            WAIT_KEY: begin
                if (enter_pulse) begin
                    entry_d = display_num;
                end else if (tmo_hit) begin
                    tmo_pulse_d  = 1'b1;
                    cur_player_d = ~cur_player_q;
                end
            end
            CHECK: begin
                if (chk_code != ERR_NONE) begin
                    err_pulse_d = 1'b1;
                    err_code_d  = chk_code;
                end else begin
                    pick_valid_d  = 1'b1;
                    pick_num_d    = val;
                    pick_player_d = cur_player_q;
                end
            end
            ISSUE: begin
                if (pick_ready) begin
                    used_mask_d  = used_mask_q | pick_bit;
                    cur_player_d = ~cur_player_q;
                    pick_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
        if (new_game) begin
            entry_d       = '0;
            pick_valid_d  = 1'b0;
            pick_num_d    = '0;
            pick_player_d = 1'b0;
            cur_player_d  = 1'b0;
            err_pulse_d   = 1'b0;
            err_code_d    = ERR_NONE;
            used_mask_d   = '0;
            tmo_pulse_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry_q       <= '0;
            pick_valid_q  <= 1'b0;
            pick_num_q    <= '0;
            pick_player_q <= 1'b0;
            cur_player_q  <= 1'b0;
            err_pulse_q   <= 1'b0;
            err_code_q    <= ERR_NONE;
            used_mask_q   <= '0;
            tmo_pulse_q   <= 1'b0;
        end else begin
            entry_q       <= entry_d;
            pick_valid_q  <= pick_valid_d;
            pick_num_q    <= pick_num_d;
            pick_player_q <= pick_player_d;
            cur_player_q  <= cur_player_d;
            err_pulse_q   <= err_pulse_d;
            err_code_q    <= err_code_d;
            used_mask_q   <= used_mask_d;
            tmo_pulse_q   <= tmo_pulse_d;
        end
    end

    assign pick_valid    = pick_valid_q;
    assign pick_num      = pick_num_q;
    assign pick_player   = pick_player_q;
    assign cur_player    = cur_player_q;
    assign err_pulse     = err_pulse_q;
    assign err_code      = err_code_q;
    assign used_mask     = used_mask_q;
    assign game_over     = (state_q == DONE);
    assign timeout_pulse = tmo_pulse_q;

endmodule
